// File: rtl/alu_stage_pkg.sv
// Shared definitions for the ALU operand stager: defaults, register roles and fill-state encoding.
package alu_stage_pkg;

    localparam int unsigned DW_DEFAULT   = 4;
    localparam int unsigned NREG_DEFAULT = 3;

    // Register roles in the default three-register configuration
    localparam int unsigned IDX_A  = 0;
    localparam int unsigned IDX_B  = 1;
    localparam int unsigned IDX_OP = 2;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } stage_state_t;

    // State reached after an accepted load, given whether every register is then valid
    function automatic stage_state_t fill_state(input logic all_valid);
        return all_valid ? ST_FULL : ST_FILLING;
    endfunction

endpackage

// File: rtl/alu_stage_prio_enc.sv
// Lowest-index-wins one-hot select over the load request vector.
module alu_stage_prio_enc #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant_c,
    output logic         any_c
);

    // Walk from the top down so the lowest set bit is the last writer
    always_comb begin
        grant_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_c    = '0;
                grant_c[i] = 1'b1;
            end
        end
    end

    assign any_c = |req;

endmodule

// File: rtl/alu_operand_stager.sv
// Operand/opcode staging registers between the microcode data bus and the ALU core,
// with per-register valid tracking, a fill FSM, a valid/ack issue handshake and bus readback.
module alu_operand_stager
    import alu_stage_pkg::*;
#(
    parameter  int unsigned DW   = DW_DEFAULT,
    parameter  int unsigned NREG = NREG_DEFAULT,
    localparam int unsigned SW   = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               grst,
    input  logic               lrst,
    input  logic [NREG-1:0]    ld,
    input  logic [DW-1:0]      bus_in,
    output logic               ld_rdy,
    input  logic               rd_en,
    input  logic [SW-1:0]      rd_sel,
    output logic [DW-1:0]      bus_out,
    output logic               bus_oe,
    output logic [NREG*DW-1:0] op_flat,
    output logic [NREG-1:0]    vld,
    output logic               out_valid,
    input  logic               alu_ack,
    output logic               ovr
);

    stage_state_t      state;
    logic [NREG*DW-1:0] data_q;
    logic [NREG-1:0]   vld_q;
    logic              ld_rdy_q;
    logic              out_valid_q;
    logic              ovr_q;

    logic [NREG-1:0]   grant_c;
    logic              any_ld_c;
    logic [NREG-1:0]   vld_next_c;

    alu_stage_prio_enc #(
        .N (NREG)
    ) u_prio (
        .req     (ld),
        .grant_c (grant_c),
        .any_c   (any_ld_c)
    );

    assign vld_next_c = vld_q | grant_c;

    // Fill FSM with register array; handshake flags are registered alongside the state
    always_ff @(posedge clk) begin
        if (grst || lrst) begin
            state       <= ST_EMPTY;
            data_q      <= '0;
            vld_q       <= '0;
            ld_rdy_q    <= 1'b1;
            out_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY, ST_FILLING: begin
                    if (any_ld_c) begin
                        for (int i = 0; i < int'(NREG); i++) begin
                            if (grant_c[i]) begin
                                data_q[i*DW +: DW] <= bus_in;
                            end
                        end
                        vld_q <= vld_next_c;
                        state <= fill_state(&vld_next_c);
                        if (&vld_next_c) begin
                            ld_rdy_q    <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    // Loads while full are dropped even in the ack cycle
                    if (any_ld_c) begin
                        ovr_q <= 1'b1;
                    end
                    if (alu_ack) begin
                        vld_q       <= '0;
                        state       <= ST_EMPTY;
                        ld_rdy_q    <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    vld_q       <= '0;
                    ld_rdy_q    <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Readback mux; out-of-range selects leave the bus undriven
    always_comb begin
        bus_out = '0;
        bus_oe  = rd_en && (32'(rd_sel) < NREG);
        if (bus_oe) begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (rd_sel == SW'(i)) begin
                    bus_out = data_q[i*DW +: DW];
                end
            end
        end
    end

    assign op_flat   = data_q;
    assign vld       = vld_q;
    assign ld_rdy    = ld_rdy_q;
    assign out_valid = out_valid_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_alu_operand_stager.sv
// Bench for alu_operand_stager: directed scenarios plus random traffic on a 3x4 and a 5x8 instance.
module tb_alu_operand_stager;
    import alu_stage_pkg::*;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 3 x 4 instance
    logic        grst3, lrst3, ack3, rd_en3;
    logic [2:0]  ld3;
    logic [3:0]  bus3;
    logic [1:0]  rd_sel3;
    logic        ld_rdy3, bus_oe3, out_valid3, ovr3;
    logic [3:0]  bus_out3;
    logic [11:0] op_flat3;
    logic [2:0]  vld3;

    // 5 x 8 instance
    logic        grst5, lrst5, ack5, rd_en5;
    logic [4:0]  ld5;
    logic [7:0]  bus5;
    logic [2:0]  rd_sel5;
    logic        ld_rdy5, bus_oe5, out_valid5, ovr5;
    logic [7:0]  bus_out5;
    logic [39:0] op_flat5;
    logic [4:0]  vld5;

    alu_operand_stager #(.DW(4), .NREG(3)) u_dut3 (
        .clk(clk), .grst(grst3), .lrst(lrst3), .ld(ld3), .bus_in(bus3), .ld_rdy(ld_rdy3),
        .rd_en(rd_en3), .rd_sel(rd_sel3), .bus_out(bus_out3), .bus_oe(bus_oe3),
        .op_flat(op_flat3), .vld(vld3), .out_valid(out_valid3), .alu_ack(ack3), .ovr(ovr3)
    );

    alu_operand_stager #(.DW(8), .NREG(5)) u_dut5 (
        .clk(clk), .grst(grst5), .lrst(lrst5), .ld(ld5), .bus_in(bus5), .ld_rdy(ld_rdy5),
        .rd_en(rd_en5), .rd_sel(rd_sel5), .bus_out(bus_out5), .bus_oe(bus_oe5),
        .op_flat(op_flat5), .vld(vld5), .out_valid(out_valid5), .alu_ack(ack5), .ovr(ovr5)
    );

    // Reference model: index 0 tracks the 3x4 instance, index 1 the 5x8 instance
    logic [7:0] m_data [2][8];
    logic [7:0] m_vld  [2];
    logic       m_ovr  [2];

    function automatic bit m_full(input int d, input int n);
        int cnt = 0;
        for (int i = 0; i < n; i++) cnt += int'(m_vld[d][i]);
        return cnt == n;
    endfunction

    function automatic void model_step(input int d, input int n, input logic rst,
                                       input logic [7:0] ld, input logic [7:0] bus, input logic ack);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_data[d][i] = 8'h00;
            m_vld[d] = 8'h00;
            m_ovr[d] = 1'b0;
        end else if (m_full(d, n)) begin
            if (ld != 8'h00) m_ovr[d] = 1'b1;
            if (ack) m_vld[d] = 8'h00;
        end else if (ld != 8'h00) begin
            for (int i = 0; i < n; i++) begin
                if (ld[i]) begin
                    m_data[d][i] = bus;
                    m_vld[d][i]  = 1'b1;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [11:0] exp_flat3();
        logic [11:0] r;
        for (int i = 0; i < 3; i++) r[i*4 +: 4] = m_data[0][i][3:0];
        return r;
    endfunction

    function automatic logic [39:0] exp_flat5();
        logic [39:0] r;
        for (int i = 0; i < 5; i++) r[i*8 +: 8] = m_data[1][i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0, 3, grst3 | lrst3, 8'(ld3), 8'(bus3), ack3);
        model_step(1, 5, grst5 | lrst5, 8'(ld5), bus5, ack5);
        #1;
    endtask

    task automatic test_reset();
        grst3 = 1'b1; grst5 = 1'b1;
        tick();
        grst3 = 1'b0; grst5 = 1'b0;
        tick();
        checks++;
        if ({op_flat3, vld3, out_valid3, ld_rdy3, ovr3, bus_oe3} !== {12'h000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset3: got flat=%h vld=%b ov=%b rdy=%b ovr=%b oe=%b, expected 000/000/0/1/0/0",
                     op_flat3, vld3, out_valid3, ld_rdy3, ovr3, bus_oe3);
        end
        checks++;
        if ({op_flat5, vld5, out_valid5, ld_rdy5, ovr5, bus_oe5} !== {40'h0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset5: got flat=%h vld=%b ov=%b rdy=%b ovr=%b oe=%b, expected 0/0/0/1/0/0",
                     op_flat5, vld5, out_valid5, ld_rdy5, ovr5, bus_oe5);
        end
    endtask

    task automatic test_fill_issue();
        ld3 = 3'b001; bus3 = 4'h3;
        tick();
        checks++;
        if ({vld3, ld_rdy3, out_valid3} !== {3'b001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fill_first: got vld=%b rdy=%b ov=%b, expected 001/1/0", vld3, ld_rdy3, out_valid3);
        end
        ld3 = 3'b010; bus3 = 4'h5;
        tick();
        ld3 = 3'b100; bus3 = 4'h1;
        tick();
        ld3 = 3'b000;
        checks++;
        if ({op_flat3, vld3, out_valid3, ld_rdy3} !== {12'h153, 3'b111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fill_full: got flat=%h vld=%b ov=%b rdy=%b, expected 153/111/1/0",
                     op_flat3, vld3, out_valid3, ld_rdy3);
        end
        ack3 = 1'b1;
        tick();
        ack3 = 1'b0;
        checks++;
        if ({op_flat3, vld3, out_valid3, ld_rdy3, ovr3} !== {12'h153, 3'b000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ack_issue: got flat=%h vld=%b ov=%b rdy=%b ovr=%b, expected 153/000/0/1/0",
                     op_flat3, vld3, out_valid3, ld_rdy3, ovr3);
        end
    endtask

    task automatic test_priority();
        ld3 = 3'b011; bus3 = 4'hA;
        tick();
        checks++;
        if ({vld3, op_flat3[IDX_A*4 +: 4], op_flat3[IDX_B*4 +: 4]} !== {3'b001, 4'hA, 4'h5}) begin
            errors++;
            $display("FAIL prio_lowest: got vld=%b a=%h b=%h, expected 001/a/5",
                     vld3, op_flat3[IDX_A*4 +: 4], op_flat3[IDX_B*4 +: 4]);
        end
        ld3 = 3'b001; bus3 = 4'h7;
        tick();
        ld3 = 3'b000;
        checks++;
        if ({op_flat3, vld3, out_valid3, ld_rdy3} !== {12'h157, 3'b001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reload: got flat=%h vld=%b ov=%b rdy=%b, expected 157/001/0/1",
                     op_flat3, vld3, out_valid3, ld_rdy3);
        end
    endtask

    task automatic test_overrun();
        ld3 = 3'b010; bus3 = 4'h2;
        tick();
        ld3 = 3'b100; bus3 = 4'h9;
        tick();
        checks++;
        if ({op_flat3, out_valid3} !== {12'h927, 1'b1}) begin
            errors++;
            $display("FAIL ovr_prefill: got flat=%h ov=%b, expected 927/1", op_flat3, out_valid3);
        end
        ld3 = 3'b010; bus3 = 4'hF; ack3 = 1'b1;
        tick();
        ld3 = 3'b000; ack3 = 1'b0;
        checks++;
        if ({op_flat3[IDX_B*4 +: 4], vld3, out_valid3, ovr3} !== {4'h2, 3'b000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovr_set: got b=%h vld=%b ov=%b ovr=%b, expected 2/000/0/1",
                     op_flat3[IDX_B*4 +: 4], vld3, out_valid3, ovr3);
        end
        ld3 = 3'b001; bus3 = 4'h4;
        tick();
        ld3 = 3'b000; ack3 = 1'b1;
        tick();
        ack3 = 1'b0;
        checks++;
        if ({vld3, op_flat3[IDX_A*4 +: 4], ovr3, ld_rdy3} !== {3'b001, 4'h4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovr_sticky_ack_ignored: got vld=%b a=%h ovr=%b rdy=%b, expected 001/4/1/1",
                     vld3, op_flat3[IDX_A*4 +: 4], ovr3, ld_rdy3);
        end
        lrst3 = 1'b1;
        tick();
        lrst3 = 1'b0;
        checks++;
        if ({ovr3, vld3, op_flat3} !== {1'b0, 3'b000, 12'h000}) begin
            errors++;
            $display("FAIL lrst_clear: got ovr=%b vld=%b flat=%h, expected 0/000/000", ovr3, vld3, op_flat3);
        end
    endtask

    task automatic test_readback();
        ld3 = 3'b100; bus3 = 4'h9;
        tick();
        ld3 = 3'b000;
        rd_en3 = 1'b1; rd_sel3 = 2'd2;
        #1;
        checks++;
        if ({bus_oe3, bus_out3} !== {1'b1, 4'h9}) begin
            errors++;
            $display("FAIL rd_sel2: got oe=%b out=%h, expected 1/9", bus_oe3, bus_out3);
        end
        rd_sel3 = 2'd3;
        #1;
        checks++;
        if ({bus_oe3, bus_out3} !== {1'b0, 4'h0}) begin
            errors++;
            $display("FAIL rd_out_of_range: got oe=%b out=%h, expected 0/0", bus_oe3, bus_out3);
        end
        rd_en3 = 1'b0; rd_sel3 = 2'd2;
        #1;
        checks++;
        if ({bus_oe3, bus_out3} !== {1'b0, 4'h0}) begin
            errors++;
            $display("FAIL rd_disabled: got oe=%b out=%h, expected 0/0", bus_oe3, bus_out3);
        end
        rd_en3 = 1'b1; ld3 = 3'b100; bus3 = 4'hC;
        #1;
        checks++;
        if (bus_out3 !== 4'h9) begin
            errors++;
            $display("FAIL rd_during_load_old: got %h, expected 9", bus_out3);
        end
        tick();
        ld3 = 3'b000;
        checks++;
        if ({bus_out3, vld3} !== {4'hC, 3'b100}) begin
            errors++;
            $display("FAIL rd_after_load_new: got out=%h vld=%b, expected c/100", bus_out3, vld3);
        end
        rd_en3 = 1'b0;
    endtask

    task automatic test_grst_midfill();
        grst3 = 1'b1;
        tick();
        grst3 = 1'b0;
        ld3 = 3'b001; bus3 = 4'h1;
        tick();
        ld3 = 3'b010; bus3 = 4'h2;
        tick();
        checks++;
        if (vld3 !== 3'b011) begin
            errors++;
            $display("FAIL midfill_vld: got %b, expected 011", vld3);
        end
        ld3 = 3'b100; bus3 = 4'h3; grst3 = 1'b1;
        tick();
        ld3 = 3'b000; grst3 = 1'b0;
        checks++;
        if ({op_flat3, vld3, out_valid3, ld_rdy3, ovr3} !== {12'h000, 3'b000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL grst_midfill: got flat=%h vld=%b ov=%b rdy=%b ovr=%b, expected 000/000/0/1/0",
                     op_flat3, vld3, out_valid3, ld_rdy3, ovr3);
        end
    endtask

    task automatic test_nreg5();
        grst5 = 1'b1;
        tick();
        grst5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld5 = 5'(1 << i); bus5 = 8'(8'h10 + i);
            tick();
            if (i < 4) begin
                checks++;
                if ({out_valid5, ld_rdy5} !== 2'b01) begin
                    errors++;
                    $display("FAIL n5_not_full_%0d: got ov=%b rdy=%b, expected 0/1", i, out_valid5, ld_rdy5);
                end
            end
        end
        ld5 = 5'b0;
        checks++;
        if ({op_flat5, vld5, out_valid5, ld_rdy5} !== {40'h14_13_12_11_10, 5'h1f, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL n5_full: got flat=%h vld=%b ov=%b rdy=%b, expected 1413121110/11111/1/0",
                     op_flat5, vld5, out_valid5, ld_rdy5);
        end
        rd_en5 = 1'b1; rd_sel5 = 3'd4;
        #1;
        checks++;
        if ({bus_oe5, bus_out5} !== {1'b1, 8'h14}) begin
            errors++;
            $display("FAIL n5_rd4: got oe=%b out=%h, expected 1/14", bus_oe5, bus_out5);
        end
        rd_sel5 = 3'd5;
        #1;
        checks++;
        if ({bus_oe5, bus_out5} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL n5_rd5: got oe=%b out=%h, expected 0/00", bus_oe5, bus_out5);
        end
        rd_en5 = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0] e_flat3;
        logic [39:0] e_flat5;
        logic        e_full, e_oe;
        logic [7:0]  e_out;
        for (int c = 0; c < 400; c++) begin
            grst3 = ($urandom_range(0, 47) == 0);
            lrst3 = ($urandom_range(0, 47) == 0);
            ld3   = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom);
            bus3  = 4'($urandom);
            ack3  = ($urandom_range(0, 2) == 0);
            rd_en3  = 1'($urandom);
            rd_sel3 = 2'($urandom);
            grst5 = ($urandom_range(0, 63) == 0);
            lrst5 = ($urandom_range(0, 63) == 0);
            ld5   = ($urandom_range(0, 2) == 0) ? 5'b0 : 5'($urandom);
            bus5  = 8'($urandom);
            ack5  = ($urandom_range(0, 3) == 0);
            rd_en5  = 1'($urandom);
            rd_sel5 = 3'($urandom);
            #1;
            e_flat3 = exp_flat3();
            e_full  = m_full(0, 3);
            checks++;
            if ({op_flat3, vld3, out_valid3, ld_rdy3, ovr3} !== {e_flat3, m_vld[0][2:0], e_full, !e_full, m_ovr[0]}) begin
                errors++;
                $display("FAIL rand3_state cyc %0d: got flat=%h vld=%b ov=%b rdy=%b ovr=%b, expected %h/%b/%b/%b/%b",
                         c, op_flat3, vld3, out_valid3, ld_rdy3, ovr3,
                         e_flat3, m_vld[0][2:0], e_full, !e_full, m_ovr[0]);
            end
            e_oe  = rd_en3 && (rd_sel3 < 2'd3);
            e_out = e_oe ? m_data[0][rd_sel3] : 8'h00;
            checks++;
            if ({bus_oe3, bus_out3} !== {e_oe, e_out[3:0]}) begin
                errors++;
                $display("FAIL rand3_rd cyc %0d: got oe=%b out=%h, expected %b/%h", c, bus_oe3, bus_out3, e_oe, e_out[3:0]);
            end
            e_flat5 = exp_flat5();
            e_full  = m_full(1, 5);
            checks++;
            if ({op_flat5, vld5, out_valid5, ld_rdy5, ovr5} !== {e_flat5, m_vld[1][4:0], e_full, !e_full, m_ovr[1]}) begin
                errors++;
                $display("FAIL rand5_state cyc %0d: got flat=%h vld=%b ov=%b rdy=%b ovr=%b, expected %h/%b/%b/%b/%b",
                         c, op_flat5, vld5, out_valid5, ld_rdy5, ovr5,
                         e_flat5, m_vld[1][4:0], e_full, !e_full, m_ovr[1]);
            end
            e_oe  = rd_en5 && (rd_sel5 < 3'd5);
            e_out = e_oe ? m_data[1][rd_sel5] : 8'h00;
            checks++;
            if ({bus_oe5, bus_out5} !== {e_oe, e_out}) begin
                errors++;
                $display("FAIL rand5_rd cyc %0d: got oe=%b out=%h, expected %b/%h", c, bus_oe5, bus_out5, e_oe, e_out);
            end
            tick();
        end
        grst3 = 1'b0; lrst3 = 1'b0; ld3 = '0; ack3 = 1'b0; rd_en3 = 1'b0;
        grst5 = 1'b0; lrst5 = 1'b0; ld5 = '0; ack5 = 1'b0; rd_en5 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        grst3 = 1'b0; lrst3 = 1'b0; ack3 = 1'b0; rd_en3 = 1'b0; ld3 = '0; bus3 = '0; rd_sel3 = '0;
        grst5 = 1'b0; lrst5 = 1'b0; ack5 = 1'b0; rd_en5 = 1'b0; ld5 = '0; bus5 = '0; rd_sel5 = '0;
        test_reset();
        test_fill_issue();
        test_priority();
        test_overrun();
        test_readback();
        test_grst_midfill();
        test_nreg5();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
